// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: per-stage stall/flush strobes for load-use, taken branches
// and data-memory wait states, plus saturating stall/flush event counters.
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Clrn,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRt,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_Rd,
    input  logic             MEM_PCSrc,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned      WaitW   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT);

    typedef enum logic [1:0] {StRun, StMemWait, StError} state_e;

    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    logic load_use, mem_busy;
    logic freeze, do_flush, do_lu;

    assign load_use = EX_MemRead && (EX_Rd != 5'd0) &&
                      ((EX_Rd == ID_Rs) || (ID_UsesRt && (EX_Rd == ID_Rt)));
    assign mem_busy = dmem_req && !dmem_ready;

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        err_d    = err_q;
        freeze   = 1'b0;
        do_flush = 1'b0;
        do_lu    = 1'b0;
        unique case (state_q)
            StRun: begin
                if (mem_busy) begin
                    freeze  = 1'b1;
                    state_d = StMemWait;
                    wait_d  = WaitW'(1);
                end else if (MEM_PCSrc) begin
                    do_flush = 1'b1;
                end else if (load_use) begin
                    do_lu = 1'b1;
                end
            end
            StMemWait: begin
                if (!dmem_ready) begin
                    freeze = 1'b1;
                    if (wait_q < WaitMax) begin
                        wait_d = wait_q + 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StError;
                    end
                end else begin
                    // Access completes: stages advance, normal hazard rules apply.
                    state_d = StRun;
                    wait_d  = '0;
                    if (MEM_PCSrc) begin
                        do_flush = 1'b1;
                    end else if (load_use) begin
                        do_lu = 1'b1;
                    end
                end
            end
            StError: begin
                freeze = 1'b1;
                err_d  = 1'b1;
            end
            default: begin
                state_d = StRun;
                wait_d  = '0;
            end
        endcase
    end

    // All strobes are forced low while reset is held.
    always_comb begin
        pc_stall     = Clrn && (freeze || do_lu);
        if_id_stall  = Clrn && (freeze || do_lu);
        if_id_flush  = Clrn && do_flush;
        id_ex_stall  = Clrn && freeze;
        id_ex_flush  = Clrn && (do_flush || do_lu);
        ex_mem_stall = Clrn && freeze;
        ex_mem_flush = Clrn && do_flush;
        mem_wb_flush = Clrn && freeze;
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state_q     <= StRun;
            wait_q      <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            if (pc_stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (do_flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign mem_err   = err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table for single-cycle hazard decoding plus
// hand sequences for memory wait, timeout, asynchronous reset and counter saturation.
module tb_hazard_ctrl;

    localparam logic [7:0] SNone = 8'h00;
    localparam logic [7:0] SLu   = 8'hC8;  // pc, if_id stall + id_ex flush
    localparam logic [7:0] SBr   = 8'h2A;  // if_id, id_ex, ex_mem flush
    localparam logic [7:0] SFrz  = 8'hD5;  // pc/if_id/id_ex/ex_mem stall + mem_wb flush

    logic       Clk = 1'b0;
    logic       Clrn = 1'b0;
    logic [4:0] ID_Rs = '0, ID_Rt = '0, EX_Rd = '0;
    logic       ID_UsesRt = 1'b0, EX_MemRead = 1'b0, MEM_PCSrc = 1'b0;
    logic       dmem_req = 1'b0, dmem_ready = 1'b0;
    logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic       ex_mem_stall, ex_mem_flush, mem_wb_flush, mem_err;
    logic [3:0] stall_cnt, flush_cnt;
    logic [7:0] strobes;

    int n_checks = 0;
    int n_fail   = 0;

    assign strobes = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                      ex_mem_stall, ex_mem_flush, mem_wb_flush};

    always #5 Clk = ~Clk;

    hazard_ctrl #(
        .MEM_TIMEOUT(4),
        .CNT_W      (4)
    ) dut (
        .Clk         (Clk),
        .Clrn        (Clrn),
        .ID_Rs       (ID_Rs),
        .ID_Rt       (ID_Rt),
        .ID_UsesRt   (ID_UsesRt),
        .EX_MemRead  (EX_MemRead),
        .EX_Rd       (EX_Rd),
        .MEM_PCSrc   (MEM_PCSrc),
        .dmem_req    (dmem_req),
        .dmem_ready  (dmem_ready),
        .pc_stall    (pc_stall),
        .if_id_stall (if_id_stall),
        .if_id_flush (if_id_flush),
        .id_ex_stall (id_ex_stall),
        .id_ex_flush (id_ex_flush),
        .ex_mem_stall(ex_mem_stall),
        .ex_mem_flush(ex_mem_flush),
        .mem_wb_flush(mem_wb_flush),
        .mem_err     (mem_err),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       mem_read;
        logic [4:0] rd;
        logic       pcsrc;
        logic       req;
        logic       ready;
        logic [7:0] exp;
        logic [3:0] exp_stall;
        logic [3:0] exp_flush;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic u,
                         input logic mr, input logic [4:0] rd, input logic pc,
                         input logic rq, input logic rdy);
        ID_Rs = rs; ID_Rt = rt; ID_UsesRt = u; EX_MemRead = mr; EX_Rd = rd;
        MEM_PCSrc = pc; dmem_req = rq; dmem_ready = rdy;
    endtask

    // Apply inputs at negedge, check strobes, then step past the next posedge.
    task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic u,
                        input logic mr, input logic [4:0] rd, input logic pc,
                        input logic rq, input logic rdy, input logic [7:0] exp,
                        input string nm);
        @(negedge Clk);
        drive(rs, rt, u, mr, rd, pc, rq, rdy);
        #1;
        check(nm, 32'(strobes), 32'(exp));
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        Clrn = 1'b0;
        #2;
        Clrn = 1'b1;
    endtask

    initial begin
        //            rs    rt    u     mr    rd    pc    rq    rdy   exp    st    fl
        vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, SNone, 4'd0, 4'd0};
        vecs[1]  = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, SLu,   4'd1, 4'd0};
        vecs[2]  = '{5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, SNone, 4'd1, 4'd0};
        vecs[3]  = '{5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, SNone, 4'd1, 4'd0};
        vecs[4]  = '{5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, SLu,   4'd2, 4'd0};
        vecs[5]  = '{5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, SNone, 4'd2, 4'd0};
        vecs[6]  = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, SBr,   4'd2, 4'd1};
        vecs[7]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, SBr,   4'd2, 4'd2};
        vecs[8]  = '{5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1, 1'b1, SLu,   4'd3, 4'd2};
        vecs[9]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, SNone, 4'd3, 4'd2};
        vecs[10] = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, SNone, 4'd3, 4'd2};

        // Reset state: hazard-causing inputs must not produce strobes while Clrn is low.
        drive(5, 0, 0, 1, 5, 1, 1, 0);
        #2;
        check("reset_strobes", 32'(strobes), 32'(SNone));
        check("reset_stall_cnt", 32'(stall_cnt), 0);
        check("reset_flush_cnt", 32'(flush_cnt), 0);
        check("reset_mem_err", 32'(mem_err), 0);
        do_reset();

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].rs, vecs[i].rt, vecs[i].uses_rt, vecs[i].mem_read, vecs[i].rd,
                 vecs[i].pcsrc, vecs[i].req, vecs[i].ready, vecs[i].exp,
                 $sformatf("vec%0d_strobes", i));
            check($sformatf("vec%0d_stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].exp_stall));
            check($sformatf("vec%0d_flush_cnt", i), 32'(flush_cnt), 32'(vecs[i].exp_flush));
        end

        // Memory wait: 3 busy cycles (branch/load-use ignored on entry), release with branch.
        do_reset();
        step(5, 0, 0, 1, 5, 1, 1, 0, SFrz, "wait_c1");
        step(0, 0, 0, 0, 0, 0, 1, 0, SFrz, "wait_c2");
        step(0, 0, 0, 0, 0, 0, 1, 0, SFrz, "wait_c3");
        step(0, 0, 0, 0, 0, 1, 1, 1, SBr,  "wait_release");
        check("wait_stall_cnt", 32'(stall_cnt), 3);
        check("wait_flush_cnt", 32'(flush_cnt), 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, SNone, "wait_back_in_run");

        // Timeout at MEM_TIMEOUT=4: error flag after 5th freeze cycle (wait_cnt reaches 4).
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 0, 0, 1, 0, SFrz, $sformatf("tmo_c%0d", i));
            check($sformatf("tmo_err_c%0d", i), 32'(mem_err), (i == 4) ? 1 : 0);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 1, 1, 1, SFrz, $sformatf("err_hold_c%0d", i));
        end
        check("err_sticky", 32'(mem_err), 1);
        check("err_stall_cnt", 32'(stall_cnt), 8);
        @(negedge Clk);
        #1;
        Clrn = 1'b0;
        #1;
        check("err_reset_strobes", 32'(strobes), 32'(SNone));
        check("err_reset_mem_err", 32'(mem_err), 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        Clrn = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, 0, SNone, "err_reset_run");

        // Asynchronous reset in the middle of MEM_WAIT.
        do_reset();
        step(0, 0, 0, 0, 0, 0, 1, 0, SFrz, "rst_wait_c1");
        step(0, 0, 0, 0, 0, 0, 1, 0, SFrz, "rst_wait_c2");
        @(negedge Clk);
        #1;
        Clrn = 1'b0;
        #1;
        check("rst_wait_strobes", 32'(strobes), 32'(SNone));
        check("rst_wait_stall_cnt", 32'(stall_cnt), 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        Clrn = 1'b1;
        #1;
        check("rst_wait_run_idle", 32'(strobes), 32'(SNone));
        @(posedge Clk);
        #1;
        step(4, 0, 0, 1, 4, 0, 0, 0, SLu, "rst_wait_lu");
        check("rst_wait_lu_cnt", 32'(stall_cnt), 1);

        // Counter saturation at CNT_W=4.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(5, 0, 0, 1, 5, 0, 0, 0, SLu, $sformatf("sat_lu_%0d", i));
            check($sformatf("sat_stall_%0d", i), 32'(stall_cnt), (i < 14) ? i + 1 : 15);
        end
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 0, 0, 1, 0, 0, SBr, $sformatf("sat_br_%0d", i));
            check($sformatf("sat_flush_%0d", i), 32'(flush_cnt), (i < 14) ? i + 1 : 15);
        end
        check("sat_stall_hold", 32'(stall_cnt), 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
